// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot rendering pipeline.
//   colour_t           : packed 24-bit {r, g, b} pixel colour
//   COLOUR_BLACK       : colour used for points that never escaped
//   DEFAULT_ITER_WIDTH : default width of an engine iteration count
//   addr_width(w, h)   : bits needed to address a w x h framebuffer
package mandel_pkg;

    localparam int DEFAULT_ITER_WIDTH = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } colour_t;

    localparam colour_t COLOUR_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    function automatic int addr_width(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous shift-register FIFO whose head entry is always register 0,
// so the head data and the valid flag come straight from flops.
//   clk, reset  : clock, synchronous active-high reset (flushes contents)
//   push        : write push_data this cycle (ignored when full and not popping)
//   push_data   : entry to append
//   pop         : drop the head this cycle (ignored when empty)
//   head_data   : current head entry
//   head_valid  : FIFO holds at least one entry
//   count       : current occupancy, 0..DEPTH
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] CNT_ZERO = {(IW + 1){1'b0}};
    localparam logic [IW:0] CNT_ONE  = {{IW{1'b0}}, 1'b1};
    localparam logic [IW:0] CNT_FULL = (IW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r      [DEPTH];
    logic [WIDTH-1:0] mem_next_s [DEPTH];
    logic [IW:0]      count_r;
    logic [IW:0]      count_next_s;
    logic             valid_r;
    logic             do_pop_s;
    logic             do_push_s;
    logic [IW-1:0]    wr_idx_s;

    // Next contents: shift down on pop, then write the new entry just past the survivors.
    always_comb begin
        mem_next_s   = mem_r;
        count_next_s = count_r;
        do_pop_s     = pop && (count_r != CNT_ZERO);
        do_push_s    = push && ((count_r != CNT_FULL) || do_pop_s);
        // With a simultaneous pop the free slot moves down by one.
        wr_idx_s     = do_pop_s ? IW'(count_r - CNT_ONE) : IW'(count_r);

        if (do_pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_next_s[i] = mem_r[i + 1];
            end
            mem_next_s[DEPTH-1] = {WIDTH{1'b0}};
        end else begin
            mem_next_s = mem_r;
        end

        if (do_push_s) begin
            mem_next_s[wr_idx_s] = push_data;
        end else begin
            mem_next_s[wr_idx_s] = mem_next_s[wr_idx_s];
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, occupancy and head-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            count_r <= CNT_ZERO;
            valid_r <= 1'b0;
        end else begin
            mem_r   <= mem_next_s;
            count_r <= count_next_s;
            valid_r <= (count_next_s != CNT_ZERO);
        end
    end

    assign head_data  = mem_r[0];
    assign head_valid = valid_r;
    assign count      = count_r;

endmodule

// File: rtl/result_collector.sv
// Collects finished Mandelbrot engine results with a round-robin arbiter,
// maps each to a framebuffer address and colour, and queues the pixel writes.
//   clk, reset   : clock, synchronous active-high reset
//   eng_done     : per-engine "result waiting" level
//   eng_x/y/iter : per-engine result fields (y runs SCREEN_HEIGHT..1, bottom row is y=1)
//   eng_ack      : one-hot, combinational; the flagged engine's result is taken this cycle
//   pix_valid    : a pixel write is presented
//   pix_ready    : the framebuffer writer takes the presented pixel this cycle
//   pix_addr     : framebuffer word address of the pixel
//   pix_colour   : {R,G,B}
//   pix_escaped  : 0 for points that reached MAX_ITER
//   fifo_count   : output FIFO occupancy
//   drop_count   : saturating count of results that fell outside the screen
module result_collector
    import mandel_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_ENGINES   = 2,
    parameter int ITER_WIDTH    = DEFAULT_ITER_WIDTH,
    parameter int MAX_ITER      = 255,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_ENGINES-1:0]                               eng_done,
    input  logic [DATA_WIDTH-1:0]                                eng_x    [NUM_ENGINES],
    input  logic [DATA_WIDTH-1:0]                                eng_y    [NUM_ENGINES],
    input  logic [ITER_WIDTH-1:0]                                eng_iter [NUM_ENGINES],
    output logic [NUM_ENGINES-1:0]                               eng_ack,
    output logic                                                 pix_valid,
    input  logic                                                 pix_ready,
    output logic [addr_width(SCREEN_WIDTH, SCREEN_HEIGHT)-1:0]   pix_addr,
    output logic [23:0]                                          pix_colour,
    output logic                                                 pix_escaped,
    output logic [$clog2(FIFO_DEPTH):0]                          fifo_count,
    output logic [15:0]                                          drop_count
);

    localparam int ADDR_W  = addr_width(SCREEN_WIDTH, SCREEN_HEIGHT);
    localparam int PTR_W   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + 24 + 1;
    localparam int WIDE_W  = 2 * DATA_WIDTH;

    localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE    = {{(PTR_W - 1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(NUM_ENGINES - 1);
    localparam logic [DATA_WIDTH-1:0] SW_D       = DATA_WIDTH'(SCREEN_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SH_D       = DATA_WIDTH'(SCREEN_HEIGHT);
    localparam logic [DATA_WIDTH-1:0] Y_MIN      = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDE_W-1:0]     SW_WIDE    = WIDE_W'(SCREEN_WIDTH);
    localparam logic [WIDE_W-1:0]     FRAME_WIDE = WIDE_W'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [ITER_WIDTH-1:0] ITER_MAX   = ITER_WIDTH'(MAX_ITER);
    localparam logic [CNT_W:0]        DEPTH_WIDE = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [15:0]           DROP_MAX   = 16'hFFFF;

    // Engine index 'offset' positions after 'base', wrapping at NUM_ENGINES.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_ENGINES) begin
            sum = sum - NUM_ENGINES;
        end else begin
            sum = sum + 0;
        end
        return PTR_W'(sum);
    endfunction

    logic [PTR_W-1:0]      ptr_r;
    logic                  grant_found_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic                  grant_valid_s;
    logic [CNT_W:0]        occ_s;
    logic                  accept_s;

    logic [DATA_WIDTH-1:0] sel_x_s;
    logic [DATA_WIDTH-1:0] sel_y_s;
    logic [ITER_WIDTH-1:0] sel_iter_s;
    logic [DATA_WIDTH-1:0] row_s;
    logic [WIDE_W-1:0]     addr_full_s;
    logic                  in_range_s;
    colour_t               colour_s;
    logic                  escaped_s;

    logic                  stage_valid_r;
    logic                  stage_in_range_r;
    logic [ADDR_W-1:0]     stage_addr_r;
    colour_t               stage_colour_r;
    logic                  stage_escaped_r;
    logic [15:0]           drop_count_r;

    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  head_valid_s;

    // Space check on registered state only: an entry sitting in the stage
    // register still needs a slot, and a pop this cycle is not counted.
    always_comb begin
        occ_s    = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, stage_valid_r};
        accept_s = (occ_s < DEPTH_WIDE);
    end

    // Round-robin search: first done engine at or after the pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = PTR_ZERO;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (!grant_found_s && eng_done[rr_index(ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_index(ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_valid_s = grant_found_s && accept_s && !reset;
    end

    // One-hot acknowledge of the granted engine.
    always_comb begin
        eng_ack = {NUM_ENGINES{1'b0}};
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_ack[i] = grant_valid_s && (grant_idx_s == PTR_W'(i));
        end
    end

    // Address/colour mapping of the granted result.
    always_comb begin
        sel_x_s     = eng_x[grant_idx_s];
        sel_y_s     = eng_y[grant_idx_s];
        sel_iter_s  = eng_iter[grant_idx_s];
        row_s       = SH_D - sel_y_s;
        addr_full_s = {{DATA_WIDTH{1'b0}}, row_s} * SW_WIDE + {{DATA_WIDTH{1'b0}}, sel_x_s};
        // The frame-size bound is implied by the x/y checks; it also keeps the
        // upper product bits meaningful before the address is truncated.
        in_range_s  = (sel_x_s < SW_D) && (sel_y_s >= Y_MIN) && (sel_y_s <= SH_D) &&
                      (addr_full_s < FRAME_WIDE);
        if (sel_iter_s >= ITER_MAX) begin
            colour_s  = COLOUR_BLACK;
            escaped_s = 1'b0;
        end else begin
            colour_s.r = sel_iter_s[7:0];
            colour_s.g = ~sel_iter_s[7:0];
            colour_s.b = {sel_iter_s[3:0], 4'h0};
            escaped_s  = 1'b1;
        end
    end

    // Round-robin pointer: moves past the engine just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= PTR_ZERO;
        end else if (grant_valid_s) begin
            ptr_r <= (grant_idx_s == PTR_LAST) ? PTR_ZERO : (grant_idx_s + PTR_ONE);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage 1 register: the mapped result of this cycle's grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_r    <= 1'b0;
            stage_in_range_r <= 1'b0;
            stage_addr_r     <= {ADDR_W{1'b0}};
            stage_colour_r   <= COLOUR_BLACK;
            stage_escaped_r  <= 1'b0;
        end else if (grant_valid_s) begin
            stage_valid_r    <= 1'b1;
            stage_in_range_r <= in_range_s;
            stage_addr_r     <= ADDR_W'(addr_full_s);
            stage_colour_r   <= colour_s;
            stage_escaped_r  <= escaped_s;
        end else begin
            stage_valid_r    <= 1'b0;
            stage_in_range_r <= stage_in_range_r;
            stage_addr_r     <= stage_addr_r;
            stage_colour_r   <= stage_colour_r;
            stage_escaped_r  <= stage_escaped_r;
        end
    end

    // Stage 2 drop counter: off-screen results are counted instead of queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r <= 16'h0000;
        end else if (stage_valid_r && !stage_in_range_r && (drop_count_r != DROP_MAX)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign push_s = stage_valid_r && stage_in_range_r;
    assign pop_s  = head_valid_s && pix_ready;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_data  ({stage_addr_r, stage_colour_r, stage_escaped_r}),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .count      (fifo_count_s)
    );

    assign pix_valid   = head_valid_s;
    assign pix_addr    = head_s[ENTRY_W-1 -: ADDR_W];
    assign pix_colour  = head_s[24:1];
    assign pix_escaped = head_s[0];
    assign fifo_count  = fifo_count_s;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned iter;
    } res_t;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] colour;
        logic        esc;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  eng_done;
    logic [31:0] eng_x    [2];
    logic [31:0] eng_y    [2];
    logic [15:0] eng_iter [2];
    logic [1:0]  eng_ack;
    logic        pix_valid;
    logic        pix_ready;
    logic [18:0] pix_addr;
    logic [23:0] pix_colour;
    logic        pix_escaped;
    logic [3:0]  fifo_count;
    logic [15:0] drop_count;

    res_t q0[$];
    res_t q1[$];
    pix_t sb[$];
    int   ack_log[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int last_ack_cyc = -1;
    int exp_drops = 0;
    bit storm = 1'b0;

    result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .eng_done    (eng_done),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_iter    (eng_iter),
        .eng_ack     (eng_ack),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_addr    (pix_addr),
        .pix_colour  (pix_colour),
        .pix_escaped (pix_escaped),
        .fifo_count  (fifo_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input res_t r);
        return (r.x < 640) && (r.y >= 1) && (r.y <= 480);
    endfunction

    function automatic pix_t expect_pix(input res_t r);
        pix_t        p;
        logic [15:0] it;
        it     = 16'(r.iter);
        p.addr = 19'((480 - r.y) * 640 + r.x);
        if (r.iter >= 255) begin
            p.colour = 24'h000000;
            p.esc    = 1'b0;
        end else begin
            p.colour = {it[7:0], ~it[7:0], it[3:0], 4'h0};
            p.esc    = 1'b1;
        end
        return p;
    endfunction

    task automatic drive_inputs();
        eng_done = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eng_x[i] = 32'd0; eng_y[i] = 32'd0; eng_iter[i] = 16'd0;
        end
        if (storm) begin
            eng_done = 2'b11;
            for (int i = 0; i < 2; i++) begin
                eng_x[i] = 32'd640; eng_y[i] = 32'd100; eng_iter[i] = 16'd7;
            end
        end else begin
            if (q0.size() > 0) begin
                eng_done[0] = 1'b1;
                eng_x[0] = q0[0].x; eng_y[0] = q0[0].y; eng_iter[0] = 16'(q0[0].iter);
            end
            if (q1.size() > 0) begin
                eng_done[1] = 1'b1;
                eng_x[1] = q1[0].x; eng_y[1] = q1[0].y; eng_iter[1] = 16'(q1[0].iter);
            end
        end
    endtask

    task automatic observe();
        logic [1:0] a;
        int         idx;
        res_t       r;
        pix_t       e;
        a = eng_ack;
        if (reset) begin
            chk("ack_in_reset", a, 2'b00);
            sb.delete();
            exp_drops = 0;
            return;
        end
        if (a != 2'b00) begin
            chk("ack_onehot", $onehot(a), 1);
            idx = a[1] ? 1 : 0;
            chk("ack_has_done", eng_done[idx], 1'b1);
            ack_log.push_back(idx);
            last_ack_cyc = cyc;
            if (storm) begin
                if (exp_drops < 65535) exp_drops++;
            end else begin
                r = (idx == 0) ? q0.pop_front() : q1.pop_front();
                if (in_rng(r)) sb.push_back(expect_pix(r));
                else if (exp_drops < 65535) exp_drops++;
            end
        end
        if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pix_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_pix", pix_valid, 1'b0);
            end else begin
                e = pix_ready ? sb.pop_front() : sb[0];
                chk("pix_addr", pix_addr, e.addr);
                chk("pix_colour", pix_colour, e.colour);
                chk("pix_escaped", pix_escaped, e.esc);
            end
        end
    endtask

    task automatic tick();
        drive_inputs();
        #1;
        observe();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + sb.size()) != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_done", q0.size() + q1.size() + sb.size(), 0);
        repeat (3) tick();
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pix_ready = 1'b0;
        drive_inputs();
        @(negedge clk);
        tick();
        tick();
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_addr", pix_addr, 19'd0);
        chk("rst_pix_colour", pix_colour, 24'h0);
        chk("rst_pix_escaped", pix_escaped, 1'b0);
        chk("rst_fifo_count", fifo_count, 4'd0);
        chk("rst_drop_count", drop_count, 16'd0);
        reset = 1'b0;

        // Single result, top-left corner, with latency measurement.
        pix_ready = 1'b1;
        first_valid_cyc = -1;
        ack_log.delete();
        q0.push_back('{5, 480, 10});
        tick();
        chk("t1_ack_same_cycle", ack_log.size(), 1);
        drain(20);
        chk("t1_latency", first_valid_cyc - last_ack_cyc, 2);

        // Bottom-right corner and non-escaping / near-limit iteration counts.
        q1.push_back('{639, 1, 255});
        q0.push_back('{0, 240, 300});
        q0.push_back('{100, 200, 254});
        drain(30);

        // Both engines busy: acks must alternate starting from engine 0.
        reset_pulse();
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{10 + i, 100, 20 + i});
            q1.push_back('{300 + i, 50, 40 + i});
        end
        ack_log.delete();
        repeat (8) tick();
        chk("rr_ack_count", ack_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ack_log.size()) chk("rr_order", ack_log[i], i % 2);
        end
        drain(30);

        // Backpressure: exactly FIFO_DEPTH results accepted, then release.
        pix_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{i, 400 - i, i * 3});
            q1.push_back('{600 - i, 20 + i, 200 + i});
        end
        ack_log.delete();
        repeat (20) tick();
        chk("stall_acks", ack_log.size(), 8);
        chk("stall_fifo_count", fifo_count, 4'd8);
        chk("stall_valid", pix_valid, 1'b1);
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("release_valid", pix_valid, 1'b1);
            tick();
        end
        drain(60);
        chk("acks_resumed", ack_log.size(), 16);

        // Out-of-range results are acked but dropped.
        q0.push_back('{640, 10, 3});
        q0.push_back('{10, 0, 3});
        q0.push_back('{7, 240, 100});
        q0.push_back('{3, 481, 1});
        drain(30);
        chk("drop_count", drop_count, exp_drops);
        chk("drop_count_3", drop_count, 16'd3);

        // Reset with three queued pixels and a full stage register.
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back('{50 + i, 300, 9});
        repeat (4) tick();
        chk("pre_rst_fifo_count", fifo_count, 4'd3);
        reset = 1'b1;
        q0.push_back('{1, 1, 1});
        q1.push_back('{2, 2, 2});
        tick();
        reset = 1'b0;
        chk("post_rst_valid", pix_valid, 1'b0);
        chk("post_rst_fifo_count", fifo_count, 4'd0);
        chk("post_rst_drops", drop_count, 16'd0);
        ack_log.delete();
        tick();
        chk("post_rst_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
        pix_ready = 1'b1;
        drain(30);

        // Saturation of the drop counter.
        storm = 1'b1;
        repeat (65540) tick();
        storm = 1'b0;
        repeat (4) tick();
        chk("drop_sat_model", drop_count, exp_drops);
        chk("drop_sat", drop_count, 16'hFFFF);
        chk("storm_no_pix", pix_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
